// File: rtl/mac_acc_pkg.sv
// Shared state encoding and default widths for the mac_acc output-stage accumulator.
package mac_acc_pkg;

    localparam int MAC_PROD_W = 20;
    localparam int MAC_ACC_W  = 28;
    localparam int MAC_OUT_W  = 24;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_RUN  = 2'd1,
        ACC_OUT  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/mac_acc_sat.sv
// Combinational ACC_W -> OUT_W reduction: clamp with flag under MAC_ACC_SAT_EN, plain wrap otherwise.
// Latency: 0 cycles (pure logic). Backpressure: none, no handshake on this path.
module mac_acc_sat #(
    parameter int ACC_W = 28,
    parameter int OUT_W = 24
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] dat_o,
    output logic             sat_o
);

`ifdef MAC_ACC_SAT_EN
    logic ovf;

    // The value fits only if every bit from the output sign bit upward matches.
    assign ovf = !((&acc_i[ACC_W-1:OUT_W-1]) || !(|acc_i[ACC_W-1:OUT_W-1]));

    always_comb begin
        dat_o = acc_i[OUT_W-1:0];
        sat_o = 1'b0;
        if (ovf) begin
            sat_o = 1'b1;
            dat_o = acc_i[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^acc_i[ACC_W-1:OUT_W];
    assign dat_o     = acc_i[OUT_W-1:0];
    assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/mac_acc.sv
// Sums cfg_len signed products per group into one result; MAC_ACC_SAT_EN selects clamping output.
// Latency: result valid the cycle after the group's last beat. Backpressure: in_rdy follows out_rdy while a result is held.
module mac_acc
    import mac_acc_pkg::*;
#(
    parameter int IN_W  = MAC_PROD_W,
    parameter int CNT_W = 8,
    parameter int ACC_W = MAC_ACC_W,
    parameter int OUT_W = MAC_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [IN_W-1:0]  in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [OUT_W-1:0] out_dat,
    output logic             out_sat,
    output logic             busy
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, len_eff;
    logic [OUT_W-1:0] out_dat_q, out_dat_d, fmt_dat;
    logic             out_sat_q, out_sat_d, fmt_sat;
    logic             beat, load;

    assign in_rdy  = (state_q == ACC_OUT) ? out_rdy : 1'b1;
    assign beat    = in_vld & in_rdy;
    assign out_vld = (state_q == ACC_OUT);
    assign busy    = (state_q != ACC_IDLE);
    assign out_dat = out_dat_q;
    assign out_sat = out_sat_q;
    assign len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;

    // Only a running group adds onto acc_q; any other beat starts a fresh sum.
    assign sum = ((state_q == ACC_RUN) ? acc_q : '0)
               + {{(ACC_W-IN_W){in_dat[IN_W-1]}}, in_dat};

    mac_acc_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc_i (sum),
        .dat_o (fmt_dat),
        .sat_o (fmt_sat)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        out_dat_d = out_dat_q;
        out_sat_d = out_sat_q;
        load      = 1'b0;
        case (state_q)
            ACC_IDLE, ACC_OUT: begin
                if (state_q == ACC_OUT && out_rdy) state_d = ACC_IDLE;
                // A beat in OUT can only coincide with the result handshake.
                if (beat) begin
                    acc_d = sum;
                    cnt_d = CNT_W'(1);
                    len_d = len_eff;
                    if (len_eff == CNT_W'(1)) begin
                        load    = 1'b1;
                        state_d = ACC_OUT;
                    end else begin
                        state_d = ACC_RUN;
                    end
                end
            end
            ACC_RUN: begin
                if (beat) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        load    = 1'b1;
                        state_d = ACC_OUT;
                    end
                end
            end
            default: state_d = ACC_IDLE;
        endcase
        if (load) begin
            out_dat_d = fmt_dat;
            out_sat_d = fmt_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            out_dat_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            out_dat_q <= out_dat_d;
            out_sat_q <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_mac_acc.sv
// Directed-vector bench for mac_acc; expected results are hand-computed sums.
module tb_mac_acc;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        in_vld;
    logic        in_rdy;
    logic [19:0] in_dat;
    logic        out_vld;
    logic        out_rdy;
    logic [23:0] out_dat;
    logic        out_sat;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mac_acc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_dat  (in_dat),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .out_sat (out_sat),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_len = 8'd0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b1;
        tick(); tick();
        n_cmp++; if (out_vld !== 1'b0)   begin n_err++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        n_cmp++; if (out_dat !== 24'd0)  begin n_err++; $display("FAIL reset_out_dat got=%h exp=0", out_dat); end
        n_cmp++; if (out_sat !== 1'b0)   begin n_err++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_rdy !== 1'b1)    begin n_err++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
    endtask

    task automatic test_basic_sum();
        cfg_len = 8'd4; out_rdy = 1'b1; in_vld = 1'b1;
        in_dat = 20'd100;     tick();
        n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL basic_busy got=%b exp=1", busy); end
        in_dat = 20'(-30);    tick();
        in_dat = 20'd7;       tick();
        n_cmp++; if (out_vld !== 1'b0)   begin n_err++; $display("FAIL basic_early_vld got=%b exp=0", out_vld); end
        in_dat = 20'd1000;    tick();
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b1)   begin n_err++; $display("FAIL basic_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== 24'd1077) begin n_err++; $display("FAIL basic_dat got=%0d exp=1077", out_dat); end
        n_cmp++; if (out_sat !== 1'b0)   begin n_err++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
        tick();
        n_cmp++; if (out_vld !== 1'b0)   begin n_err++; $display("FAIL basic_vld_drop got=%b exp=0", out_vld); end
        n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_zero_len();
        cfg_len = 8'd0; out_rdy = 1'b1; in_vld = 1'b1;
        in_dat = 20'(-5); tick();
        n_cmp++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL zlen_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== 24'hFFFFFB) begin n_err++; $display("FAIL zlen_dat got=%h exp=fffffb", out_dat); end
        in_dat = 20'd3; tick();
        n_cmp++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL zlen_b2b_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== 24'd3)     begin n_err++; $display("FAIL zlen_b2b_dat got=%h exp=3", out_dat); end
        in_vld = 1'b0; tick();
        n_cmp++; if (out_vld !== 1'b0)      begin n_err++; $display("FAIL zlen_drop got=%b exp=0", out_vld); end
    endtask

    task automatic test_back_to_back();
        cfg_len = 8'd2; out_rdy = 1'b0; in_vld = 1'b1;
        in_dat = 20'd5; tick();
        in_dat = 20'd6; tick();
        in_dat = 20'd9;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (in_rdy !== 1'b0)   begin n_err++; $display("FAIL bp_in_rdy[%0d] got=%b exp=0", i, in_rdy); end
            n_cmp++; if (out_vld !== 1'b1)  begin n_err++; $display("FAIL bp_vld[%0d] got=%b exp=1", i, out_vld); end
            n_cmp++; if (out_dat !== 24'd11) begin n_err++; $display("FAIL bp_dat[%0d] got=%0d exp=11", i, out_dat); end
            tick();
        end
        out_rdy = 1'b1; #1;
        n_cmp++; if (in_rdy !== 1'b1)       begin n_err++; $display("FAIL bp_release_rdy got=%b exp=1", in_rdy); end
        tick();
        n_cmp++; if (out_vld !== 1'b0)      begin n_err++; $display("FAIL bp_after_hs_vld got=%b exp=0", out_vld); end
        n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL bp_after_hs_busy got=%b exp=1", busy); end
        in_dat = 20'd1; tick();
        in_vld = 1'b0;
        n_cmp++; if (out_dat !== 24'd10)    begin n_err++; $display("FAIL bp_next_dat got=%0d exp=10", out_dat); end
        tick();
    endtask

    task automatic test_saturation();
        logic [23:0] exp_dat;
        logic        exp_sat;
`ifdef MAC_ACC_SAT_EN
        exp_dat = 24'h7FFFFF; exp_sat = 1'b1;
`else
        exp_dat = 24'h9FFFEC; exp_sat = 1'b0;
`endif
        cfg_len = 8'd20; out_rdy = 1'b1; in_vld = 1'b1; in_dat = 20'd524287;
        for (int i = 0; i < 20; i++) tick();
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL sat_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== exp_dat)   begin n_err++; $display("FAIL sat_dat got=%h exp=%h", out_dat, exp_dat); end
        n_cmp++; if (out_sat !== exp_sat)   begin n_err++; $display("FAIL sat_flag got=%b exp=%b", out_sat, exp_sat); end
        tick();
    endtask

    task automatic test_reset_mid_group();
        cfg_len = 8'd4; out_rdy = 1'b1; in_vld = 1'b1; in_dat = 20'd50;
        tick(); tick();
        in_vld = 1'b0; rst_n = 1'b0;
        tick();
        n_cmp++; if (out_vld !== 1'b0)      begin n_err++; $display("FAIL rstmid_vld got=%b exp=0", out_vld); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        cfg_len = 8'd2; in_vld = 1'b1; in_dat = 20'd1;
        tick(); tick();
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL rstmid_new_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== 24'd2)     begin n_err++; $display("FAIL rstmid_new_dat got=%0d exp=2", out_dat); end
        tick();
    endtask

    task automatic test_bubbles();
        cfg_len = 8'd3; out_rdy = 1'b1;
        in_vld = 1'b1; in_dat = 20'd10; tick();
        cfg_len = 8'd1;
        in_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL bub_busy_a[%0d] got=%b exp=1", i, busy); end
        end
        in_vld = 1'b1; in_dat = 20'd20; tick();
        n_cmp++; if (out_vld !== 1'b0)      begin n_err++; $display("FAIL bub_early_vld got=%b exp=0", out_vld); end
        in_vld = 1'b0; tick();
        n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL bub_busy_b got=%b exp=1", busy); end
        in_vld = 1'b1; in_dat = 20'd30; tick();
        in_vld = 1'b0;
        n_cmp++; if (out_vld !== 1'b1)      begin n_err++; $display("FAIL bub_vld got=%b exp=1", out_vld); end
        n_cmp++; if (out_dat !== 24'd60)    begin n_err++; $display("FAIL bub_dat got=%0d exp=60", out_dat); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_zero_len();
        test_back_to_back();
        test_saturation();
        test_reset_mid_group();
        test_bubbles();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
